// File: rtl/arith_result_framer.sv
// Byte-serial framer for one arithmetic result set per handshake: HDR, sum, prod hi/lo, diff, quotient, remainder.
// Optional XOR checksum byte appended when ARITH_FRAME_CHK_EN is defined.
module arith_result_framer #(
    parameter logic [7:0]  FRAME_HDR = 8'hA5,
    parameter int unsigned IDLE_GAP  = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  sum,
    input  logic [15:0] prod,
    input  logic [7:0]  diff,
    input  logic [7:0]  quotient,
    input  logic [7:0]  remainder,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy,
    output logic [7:0]  frame_cnt
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SEND = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;
`ifdef ARITH_FRAME_CHK_EN
    localparam logic [2:0] LAST_IDX = 3'd7;
`else
    localparam logic [2:0] LAST_IDX = 3'd6;
`endif
    // Gap counter counts down to zero, so GAP lasts exactly IDLE_GAP cycles.
    localparam int unsigned GAP_LOAD_I = (IDLE_GAP != 0) ? IDLE_GAP - 1 : 0;
    localparam logic [3:0]  GAP_LOAD   = GAP_LOAD_I[3:0];

    logic [1:0]  state;
    logic [2:0]  idx;
    logic [7:0]  sum_q, diff_q, quo_q, rem_q;
    logic [15:0] prod_q;
    logic [3:0]  gap_cnt;
    logic [7:0]  frame_cnt_q;
    logic [7:0]  byte_sel;

    always_comb begin
        byte_sel = 8'h00;
        case (idx)
            3'd0:    byte_sel = FRAME_HDR;
            3'd1:    byte_sel = sum_q;
            3'd2:    byte_sel = prod_q[15:8];
            3'd3:    byte_sel = prod_q[7:0];
            3'd4:    byte_sel = diff_q;
            3'd5:    byte_sel = quo_q;
            3'd6:    byte_sel = rem_q;
`ifdef ARITH_FRAME_CHK_EN
            default: byte_sel = FRAME_HDR ^ sum_q ^ prod_q[15:8] ^ prod_q[7:0] ^ diff_q ^ quo_q ^ rem_q;
`else
            default: byte_sel = 8'h00;
`endif
        endcase
    end

    // Outputs decode straight from registered state, so they are stable while stalled.
    assign out_valid = (state == S_SEND);
    assign out_data  = out_valid ? byte_sel : 8'h00;
    assign out_last  = out_valid && (idx == LAST_IDX);
    assign in_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign frame_cnt = frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            idx         <= 3'd0;
            sum_q       <= 8'h00;
            prod_q      <= 16'h0000;
            diff_q      <= 8'h00;
            quo_q       <= 8'h00;
            rem_q       <= 8'h00;
            gap_cnt     <= 4'd0;
            frame_cnt_q <= 8'h00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        sum_q  <= sum;
                        prod_q <= prod;
                        diff_q <= diff;
                        quo_q  <= quotient;
                        rem_q  <= remainder;
                        idx    <= 3'd0;
                        state  <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (out_ready) begin
                        if (idx == LAST_IDX) begin
                            frame_cnt_q <= frame_cnt_q + 8'd1;
                            idx         <= 3'd0;
                            if (IDLE_GAP != 0) begin
                                gap_cnt <= GAP_LOAD;
                                state   <= S_GAP;
                            end else begin
                                state   <= S_IDLE;
                            end
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end
                end
                S_GAP: begin
                    if (gap_cnt == 4'd0) state <= S_IDLE;
                    else                 gap_cnt <= gap_cnt - 4'd1;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_arith_result_framer.sv
// Directed bench for arith_result_framer: default-gap instance plus an IDLE_GAP=3 instance.
module tb_arith_result_framer;
`ifdef ARITH_FRAME_CHK_EN
    localparam int NB = 8;
`else
    localparam int NB = 7;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_valid_g;
    logic        out_ready, out_ready_g;
    logic [7:0]  sum, diff, quotient, remainder;
    logic [15:0] prod;
    logic        in_ready, out_valid, out_last, busy;
    logic        in_ready_g, out_valid_g, out_last_g, busy_g;
    logic [7:0]  out_data, frame_cnt, out_data_g, frame_cnt_g;

    int errors = 0;
    int checks = 0;
    logic [7:0] exp_b [8];

    always #5 clk = ~clk;

    arith_result_framer dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sum(sum), .prod(prod), .diff(diff), .quotient(quotient), .remainder(remainder),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_last(out_last), .busy(busy), .frame_cnt(frame_cnt)
    );

    arith_result_framer #(.FRAME_HDR(8'hA5), .IDLE_GAP(3)) dut_g (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid_g), .in_ready(in_ready_g),
        .sum(sum), .prod(prod), .diff(diff), .quotient(quotient), .remainder(remainder),
        .out_data(out_data_g), .out_valid(out_valid_g), .out_ready(out_ready_g),
        .out_last(out_last_g), .busy(busy_g), .frame_cnt(frame_cnt_g)
    );

    function automatic logic [7:0] model_byte(input logic [47:0] v, input int i);
        logic [7:0] b [8];
        b[0] = 8'hA5;      b[1] = v[47:40]; b[2] = v[39:32]; b[3] = v[31:24];
        b[4] = v[23:16];   b[5] = v[15:8];  b[6] = v[7:0];
        b[7] = b[0] ^ b[1] ^ b[2] ^ b[3] ^ b[4] ^ b[5] ^ b[6];
        return b[i];
    endfunction

    task automatic send_set(input logic [7:0] s, input logic [15:0] p, input logic [7:0] d,
                            input logic [7:0] q, input logic [7:0] r);
        sum = s; prod = p; diff = d; quotient = q; remainder = r;
        in_valid = 1'b1;
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL send_in_ready got=%b exp=1", in_ready); end
        @(negedge clk);
        in_valid = 1'b0;
        // Scramble inputs after capture; the frame must not follow them.
        sum = 8'($urandom); prod = 16'($urandom); diff = 8'($urandom);
        quotient = 8'($urandom); remainder = 8'($urandom);
        checks++;
        if (out_valid !== 1'b1) begin errors++; $display("FAIL first_byte_latency out_valid=%b exp=1", out_valid); end
    endtask

    // Receives one frame against exp_b; bp selects the 1,0,0,1 out_ready pattern.
    task automatic recv_frame(input bit bp, input string nm);
        int idx = 0;
        int k = 0;
        logic rdy;
        logic [7:0] fc0 = frame_cnt;
        while (idx < NB && k < 100) begin
            checks++;
            if (out_valid !== 1'b1 || out_data !== exp_b[idx] || out_last !== (idx == NB - 1)) begin
                errors++;
                $display("FAIL %s byte%0d got v=%b d=%h l=%b exp v=1 d=%h l=%b",
                         nm, idx, out_valid, out_data, out_last, exp_b[idx], (idx == NB - 1));
            end
            checks++;
            if (frame_cnt !== fc0) begin errors++; $display("FAIL %s cnt_early got=%h exp=%h", nm, frame_cnt, fc0); end
            rdy = bp ? ((k % 4) == 0 || (k % 4) == 3) : 1'b1;
            out_ready = rdy;
            @(negedge clk);
            if (rdy) idx++;
            k++;
        end
        out_ready = 1'b0;
        checks++;
        if (k >= 100) begin errors++; $display("FAIL %s timeout got=%0d bytes exp=%0d", nm, idx, NB); end
        checks++;
        if (frame_cnt !== 8'(fc0 + 8'd1)) begin errors++; $display("FAIL %s cnt got=%h exp=%h", nm, frame_cnt, 8'(fc0 + 8'd1)); end
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s post_frame rdy=%b v=%b busy=%b exp 1,0,0", nm, in_ready, out_valid, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_valid_g = 1'b0; out_ready = 1'b0; out_ready_g = 1'b0;
        sum = 8'h00; prod = 16'h0000; diff = 8'h00; quotient = 8'h00; remainder = 8'h00;
        @(negedge clk); @(negedge clk);
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_last !== 1'b0 || out_data !== 8'h00 ||
            busy !== 1'b0 || frame_cnt !== 8'h00) begin
            errors++;
            $display("FAIL reset_state rdy=%b v=%b l=%b d=%h busy=%b cnt=%h exp 1,0,0,00,0,00",
                     in_ready, out_valid, out_last, out_data, busy, frame_cnt);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single();
        exp_b = '{8'hA5, 8'h1E, 8'h00, 8'hC8, 8'h0A, 8'h02, 8'h00, 8'h7B};
        send_set(8'd30, 16'd200, 8'd10, 8'd2, 8'd0);
        recv_frame(1'b0, "single");
    endtask

    task automatic test_backpressure();
        exp_b = '{8'hA5, 8'h46, 8'h03, 8'hE8, 8'h1E, 8'h02, 8'h0A, 8'h1E};
        send_set(8'd70, 16'd1000, 8'd30, 8'd2, 8'd10);
        recv_frame(1'b1, "backpressure");
    endtask

    task automatic test_wrap();
        exp_b = '{8'hA5, 8'h07, 8'h00, 8'h00, 8'hF9, 8'h00, 8'h00, 8'h5B};
        send_set(8'd7, 16'd0, 8'hF9, 8'd0, 8'd0);
        recv_frame(1'b0, "wrap");
    endtask

    task automatic test_reset_mid();
        exp_b = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h00};
        send_set(8'h11, 16'h2233, 8'h44, 8'h55, 8'h66);
        out_ready = 1'b1;
        repeat (3) @(negedge clk);
        out_ready = 1'b0;
        checks++;
        if (out_data !== 8'h33) begin errors++; $display("FAIL rst_mid_byte3 got=%h exp=33", out_data); end
        rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || frame_cnt !== 8'h00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid v=%b rdy=%b cnt=%h busy=%b exp 0,1,00,0", out_valid, in_ready, frame_cnt, busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL rst_mid_release v=%b rdy=%b exp 0,1", out_valid, in_ready);
        end
        exp_b = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'hA2};
        send_set(8'h01, 16'h0203, 8'h04, 8'h05, 8'h06);
        recv_frame(1'b0, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [47:0] q[$];
        int bi = 0;
        int ndone = 0;
        bit exp_rdy = 1'b0;
        out_ready = 1'b1;
        for (int cyc = 0; cyc < 60 + 2 * (NB + 1) + 2; cyc++) begin
            if (exp_rdy) begin
                checks++;
                if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_rearm cyc=%0d rdy=%b exp=1", cyc, in_ready); end
                exp_rdy = 1'b0;
            end
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b_spurious cyc=%0d d=%h exp no byte", cyc, out_data);
                end else if (out_data !== model_byte(q[0], bi) || out_last !== (bi == NB - 1)) begin
                    errors++;
                    $display("FAIL b2b_byte cyc=%0d idx=%0d got d=%h l=%b exp d=%h l=%b",
                             cyc, bi, out_data, out_last, model_byte(q[0], bi), (bi == NB - 1));
                end
                if (bi == NB - 1) begin
                    if (q.size() != 0) void'(q.pop_front());
                    bi = 0; exp_rdy = 1'b1; ndone++;
                end else begin
                    bi++;
                end
            end
            if (cyc < 60) begin
                in_valid = 1'b1;
                sum = 8'($urandom); prod = 16'($urandom); diff = 8'($urandom);
                quotient = 8'($urandom); remainder = 8'($urandom);
            end else begin
                in_valid = 1'b0;
            end
            if (in_ready && in_valid) q.push_back({sum, prod, diff, quotient, remainder});
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++;
        if (ndone != (60 + NB) / (NB + 1) || q.size() != 0) begin
            errors++;
            $display("FAIL b2b_frames got=%0d pending=%0d exp=%0d pending=0", ndone, q.size(), (60 + NB) / (NB + 1));
        end
    endtask

    task automatic g_frame(input string nm);
        int k = 0;
        while (!in_ready_g && k < 50) begin @(negedge clk); k++; end
        in_valid_g = 1'b1;
        @(negedge clk);
        in_valid_g = 1'b0;
        while (!(out_valid_g && out_last_g) && k < 50) begin @(negedge clk); k++; end
        if (k >= 50) begin
            checks++; errors++;
            $display("FAIL %s timeout got=%0d exp<50 cycles", nm, k);
        end
        @(negedge clk);
    endtask

    task automatic test_gap();
        out_ready_g = 1'b1;
        sum = 8'h10; prod = 16'h2030; diff = 8'h40; quotient = 8'h50; remainder = 8'h60;
        g_frame("gap_first");
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (in_ready_g !== 1'b0 || busy_g !== 1'b1 || out_valid_g !== 1'b0) begin
                errors++;
                $display("FAIL gap_hold%0d rdy=%b busy=%b v=%b exp 0,1,0", i, in_ready_g, busy_g, out_valid_g);
            end
            @(negedge clk);
        end
        checks++;
        if (in_ready_g !== 1'b1) begin errors++; $display("FAIL gap_release rdy=%b exp=1", in_ready_g); end
        checks++;
        if (frame_cnt_g !== 8'h01) begin errors++; $display("FAIL gap_cnt1 got=%h exp=01", frame_cnt_g); end
        for (int i = 0; i < 254; i++) g_frame("gap_loop");
        checks++;
        if (frame_cnt_g !== 8'hFF) begin errors++; $display("FAIL gap_cnt255 got=%h exp=ff", frame_cnt_g); end
        g_frame("gap_last");
        checks++;
        if (frame_cnt_g !== 8'h00) begin errors++; $display("FAIL gap_cnt_wrap got=%h exp=00", frame_cnt_g); end
        out_ready_g = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_wrap();
        test_reset_mid();
        test_back_to_back();
        test_gap();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
